alu_writeback_stage: RTL and testbench
======================================

// Module: alu_writeback_stage
// PURPOSE
//   Writeback stage directly downstream of the ALU. Accepts each ALU result with its
//   Z/N/V flags over a valid/ready handshake and updates the architectural status flags.
//   Buffers results in a 2-entry FIFO and presents them to the register-file write port.
//   Decouples the ALU from write-port stalls without a combinational ready path.
// PARAMETERS
//   word_len  16  data width; must match the ALU word_len
//   op_len    16  opcode width; must match the ALU op_len
//   addr_len  3   register-file destination index width
// PORTS
//   clk          in   1         rising-edge clock
//   rst          in   1         asynchronous, active-high reset
//   in_valid     in   1         ALU result presented
//   in_ready     out  1         stage can accept (registered)
//   in_ans       in   word_len  ALU result
//   in_overflow  in   1         ALU did_overflow (carry/borrow out)
//   in_negative  in   1         ALU is_negative
//   in_zero      in   1         ALU is_zero
//   in_op        in   op_len    opcode that produced in_ans
//   in_dest      in   addr_len  destination register index
//   in_flag_we   in   1         1 = this result updates the status flags
//   flush        in   1         synchronous discard of all buffered results
//   out_valid    out  1         head entry valid
//   out_ready    in   1         register file takes head entry
//   out_data     out  word_len  head entry data
//   out_dest     out  addr_len  head entry destination
//   flag_z       out  1         status: zero
//   flag_n       out  1         status: negative
//   flag_v       out  1         status: overflow/carry
//   count        out  2         entries held (0..2)
// BEHAVIOUR
//   Reset (async, rst=1): count=0, out_valid=0, out_data=0, out_dest=0,
//     flag_z=flag_n=flag_v=0. in_ready=0 while rst=1 and 1 from the first edge after release.
//   Push: in_valid & in_ready at a clk edge. Pop: out_valid & out_ready at a clk edge.
//   in_ready = (count<2), registered from the count state. No combinational path
//     from out_ready to in_ready. When full, a same-cycle pop does not allow a push.
//   FIFO: in-order, 2 entries of {in_ans,in_dest}; out_* always reflect the head entry.
//     Latency: a push into an empty stage gives out_valid=1 in the next cycle.
//     Push+pop in the same cycle (count=1) keeps count=1; the new entry becomes head.
//     Pointers wrap modulo 2. out_data/out_dest keep the last value when count=0.
//   Flags: updated on the push edge, not on drain.
//     The sequencer sees the new flags one cycle after accept.
//     If in_flag_we=1: flag_z<=in_zero and flag_n<=in_negative.
//       flag_v<=in_overflow only when in_op==0 (add) or in_op==1 (sub).
//       For all other opcodes flag_v is unchanged, because ALU overflow is stale for logic ops.
//     If in_flag_we=0: all flags are unchanged.
//   Flush: the next edge sets count=0 and out_valid=0. Flags are kept.
//     Flush has priority over a concurrent push: the pushed word is discarded
//     and its flag update is suppressed. A concurrent pop is a no-op.
//   The stage performs no arithmetic; widths pass through unchanged.
//   Asserting rst mid-stream drops all entries immediately and clears the flags.
// TESTING
//   1 Reset: assert rst mid-stream with count=2 -> out_valid=0, count=0, flags 000
//     immediately; in_ready=1 one edge after release.
//   2 Single push: ans=16'h0000, zero=1, op=0, ovf=1, we=1, dest=5 -> next cycle
//     out_valid=1, out_data=0, out_dest=5, flag_z=1, flag_v=1.
//   3 Backpressure: out_ready=0, push 16'h1111, 16'h2222, attempt 16'h3333 ->
//     count=2, in_ready=0, 3333 not taken; drain order 1111 then 2222.
//   4 Flag rule: push op=4 (xor), ovf=1, we=1 after flag_v=0 -> flag_v stays 0;
//     push op=1, ovf=1 -> flag_v=1; push with we=0 -> flags unchanged.
//   5 Simultaneous: count=1, push+pop same edge -> count stays 1, head = new word.
//   6 Flush with in_valid=1, we=1, zero=1 -> count=0, out_valid=0, flag_z unchanged.

Source files
------------

// File: rtl/alu_wb_if.sv
// Handshake bundle between the ALU, the writeback stage and the register-file write port.
interface alu_wb_if #(
    parameter int word_len = 16,
    parameter int op_len   = 16,
    parameter int addr_len = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [word_len-1:0] in_ans;
    logic                in_overflow;
    logic                in_negative;
    logic                in_zero;
    logic [op_len-1:0]   in_op;
    logic [addr_len-1:0] in_dest;
    logic                in_flag_we;
    logic                out_valid;
    logic                out_ready;
    logic [word_len-1:0] out_data;
    logic [addr_len-1:0] out_dest;

    modport master (
        output in_valid, in_ans, in_overflow, in_negative, in_zero, in_op, in_dest,
               in_flag_we, out_ready,
        input  in_ready, out_valid, out_data, out_dest
    );

    modport slave (
        input  in_valid, in_ans, in_overflow, in_negative, in_zero, in_op, in_dest,
               in_flag_we, out_ready,
        output in_ready, out_valid, out_data, out_dest
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry result FIFO toward the register file plus the
// architectural Z/N/V status flags, updated when a result is accepted.
module alu_writeback_stage #(
    parameter int word_len = 16,
    parameter int op_len   = 16,
    parameter int addr_len = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    alu_wb_if.slave    bus,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_v,
    output logic [1:0] count
);
    localparam int entry_w = word_len + addr_len;

    logic [entry_w-1:0]  mem_q [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [word_len-1:0] out_data_q, out_data_d;
    logic [addr_len-1:0] out_dest_q, out_dest_d;
    logic                flag_z_q, flag_n_q, flag_v_q;
    logic                push, pop, arith_op;
    logic [entry_w-1:0]  in_entry, head_entry;

    // Flush wins over both handshakes, so neither side sees a transfer that cycle.
    assign push     = bus.in_valid & in_ready_q & ~flush;
    assign pop      = out_valid_q & bus.out_ready & ~flush;
    assign in_entry = {bus.in_ans, bus.in_dest};
    assign arith_op = (bus.in_op == op_len'(0)) || (bus.in_op == op_len'(1));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        out_dest_d = out_dest_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ pop;
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
        end
        // The head may be the word being written this edge (empty, or push+pop at count 1).
        head_entry = (push && (wr_ptr_q == rd_ptr_d)) ? in_entry : mem_q[rd_ptr_d];
        if (count_d != 2'd0) begin
            {out_data_d, out_dest_d} = head_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= (count_d != 2'd2);
            out_valid_q <= (count_d != 2'd0);
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
            if (push && bus.in_flag_we) begin
                flag_z_q <= bus.in_zero;
                flag_n_q <= bus.in_negative;
                // Overflow is only meaningful for add/sub; logic ops leave it stale.
                if (arith_op) begin
                    flag_v_q <= bus.in_overflow;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_dest  = out_dest_q;
    assign flag_z        = flag_z_q;
    assign flag_n        = flag_n_q;
    assign flag_v        = flag_v_q;
    assign count         = count_q;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_writeback_stage;
    logic       clk;
    logic       rst;
    logic       flush;
    logic       flag_z, flag_n, flag_v;
    logic [1:0] count;
    int         total;
    int         bad;

    alu_wb_if #(.word_len(16), .op_len(16), .addr_len(3)) bus ();

    alu_writeback_stage #(.word_len(16), .op_len(16), .addr_len(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .bus    (bus.slave),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_v (flag_v),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ordered list of {data,dest}, plus flags and the registered ready.
    logic [18:0] m_q[$];
    logic        m_z, m_n, m_v, m_rdy;
    logic [15:0] m_data;
    logic [2:0]  m_dest;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_rdy = 1'b0;
        m_data = 16'h0; m_dest = 3'h0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".in_ready"},  32'(bus.in_ready),  32'(m_rdy));
        chk({ph, ".out_valid"}, 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk({ph, ".count"},     32'(count),         32'(m_q.size()));
        chk({ph, ".out_data"},  32'(bus.out_data),  32'(m_data));
        chk({ph, ".out_dest"},  32'(bus.out_dest),  32'(m_dest));
        chk({ph, ".flags"},     32'({flag_z, flag_n, flag_v}), 32'({m_z, m_n, m_v}));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input string ph, input logic v, input logic [15:0] ans,
                        input logic ovf, input logic neg, input logic zero,
                        input logic [15:0] op, input logic [2:0] dest, input logic we,
                        input logic fl, input logic ordy);
        logic do_push, do_pop;
        bus.in_valid = v; bus.in_ans = ans; bus.in_overflow = ovf;
        bus.in_negative = neg; bus.in_zero = zero; bus.in_op = op;
        bus.in_dest = dest; bus.in_flag_we = we; flush = fl; bus.out_ready = ordy;
        do_push = v && m_rdy && !fl;
        do_pop  = (m_q.size() != 0) && ordy && !fl;
        @(posedge clk);
        if (fl) m_q.delete();
        else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back({ans, dest});
        end
        if (do_push && we) begin
            m_z = zero; m_n = neg;
            if (op == 16'd0 || op == 16'd1) m_v = ovf;
        end
        m_rdy = (m_q.size() < 2);
        if (m_q.size() != 0) {m_data, m_dest} = m_q[0];
        #1;
        check_all(ph);
    endtask

    task automatic idle(input string ph, input logic ordy);
        step(ph, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 3'h0, 1'b0, 1'b0, ordy);
    endtask

    task automatic push(input string ph, input logic [15:0] ans, input logic [2:0] dest,
                        input logic [15:0] op, input logic ovf, input logic zero,
                        input logic we, input logic ordy);
        step(ph, 1'b1, ans, ovf, ans[15], zero, op, dest, we, 1'b0, ordy);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_ans = '0; bus.in_overflow = 1'b0;
        bus.in_negative = 1'b0; bus.in_zero = 1'b0; bus.in_op = '0;
        bus.in_dest = '0; bus.in_flag_we = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        idle("release", 1'b0);
        chk("release.in_ready_lit", 32'(bus.in_ready), 32'd1);

        // Single push into empty stage
        push("t2", 16'h0000, 3'd5, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t2.out_valid", 32'(bus.out_valid), 32'd1);
        chk("t2.out_dest",  32'(bus.out_dest),  32'd5);
        chk("t2.flag_z",    32'(flag_z),        32'd1);
        chk("t2.flag_v",    32'(flag_v),        32'd1);
        idle("t2.drain", 1'b1);

        // Backpressure
        push("t3.a", 16'h1111, 3'd1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        push("t3.b", 16'h2222, 3'd2, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        push("t3.c", 16'h3333, 3'd3, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3.count",    32'(count),        32'd2);
        chk("t3.in_ready", 32'(bus.in_ready), 32'd0);
        chk("t3.head1",    32'(bus.out_data), 32'h1111);
        idle("t3.pop1", 1'b1);
        chk("t3.head2",    32'(bus.out_data), 32'h2222);
        idle("t3.pop2", 1'b1);
        chk("t3.empty",    32'(count),        32'd0);
        chk("t3.keep",     32'(bus.out_data), 32'h2222);

        // Flag rules
        push("t4.clr", 16'h0010, 3'd1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4.v0", 32'(flag_v), 32'd0);
        push("t4.xor", 16'h0020, 3'd2, 16'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t4.xor_v", 32'(flag_v), 32'd0);
        push("t4.sub", 16'h8000, 3'd3, 16'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t4.sub_v", 32'(flag_v), 32'd1);
        chk("t4.sub_n", 32'(flag_n), 32'd1);
        push("t4.nowe", 16'h0000, 3'd4, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4.nowe_flags", 32'({flag_z, flag_n, flag_v}), 32'b011);
        idle("t4.drain", 1'b1);

        // Simultaneous push and pop at count 1
        push("t5.a", 16'hAAAA, 3'd6, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        push("t5.b", 16'h5555, 3'd7, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5.count", 32'(count),        32'd1);
        chk("t5.head",  32'(bus.out_data), 32'h5555);
        chk("t5.dest",  32'(bus.out_dest), 32'd7);

        // Flush beats a concurrent push
        step("t6", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd0, 3'd1, 1'b1, 1'b1, 1'b1);
        chk("t6.count",     32'(count),         32'd0);
        chk("t6.out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6.flag_z",    32'(flag_z),        32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 5)), 3'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end

        // Mid-stream reset with two entries held and flags set
        idle("t1.drain", 1'b1);
        idle("t1.drain2", 1'b1);
        push("t1.a", 16'h8001, 3'd1, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        push("t1.b", 16'h0002, 3'd2, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t1.full", 32'(count), 32'd2);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_all("t1.async");
        chk("t1.flags", 32'({flag_z, flag_n, flag_v}), 32'd0);
        chk("t1.count", 32'(count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t1.rdy_low", 32'(bus.in_ready), 32'd0);
        idle("t1.release", 1'b0);
        chk("t1.rdy_high", 32'(bus.in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
